// File: rtl/sdhci_cmd_arbiter.sv
// Shares the SD command issuer between driver commands and Auto CMD12, raising error/done set-pulses.
// Optional: define SDHCI_ACMD12_ERR_GATE_EN to drop the pending command when the first command fails.

module sdhci_cmd_arbiter #(
  parameter int         ErrW    = 4,
  parameter logic [5:0] Cmd12Ix = 6'd12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sw_rst_cmd_i,
  input  logic            drv_req_i,
  input  logic [5:0]      drv_index_i,
  input  logic [31:0]     drv_arg_i,
  input  logic [1:0]      drv_rsp_type_i,
  input  logic            acmd12_req_i,
  output logic            iss_valid_o,
  input  logic            iss_ready_i,
  output logic [5:0]      iss_index_o,
  output logic [31:0]     iss_arg_o,
  output logic [1:0]      iss_rsp_type_o,
  input  logic            iss_done_i,
  input  logic [ErrW-1:0] iss_err_i,
  output logic            cmd_inhibit_o,
  output logic [3:0]      nerr_set_o,
  output logic [7:0]      aerr_set_o,
  output logic            drv_done_o,
  output logic            acmd12_done_o
);

`ifdef SDHCI_ACMD12_ERR_GATE_EN
  localparam bit GateEn = 1'b1;
`else
  localparam bit GateEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

  state_t      state;
  logic        cur_is_a12;
  logic        drv_pend;
  logic        a12_pend;
  logic [5:0]  drv_index_q;
  logic [31:0] drv_arg_q;
  logic [1:0]  drv_rsp_type_q;

  logic busy;
  logic drv_new;
  logic a12_new;
  logic cmd_err;

  // A request is new only if the same kind is neither pending nor owning the slot.
  assign busy    = (state != IDLE);
  assign drv_new = drv_req_i && !drv_pend && !(busy && !cur_is_a12);
  assign a12_new = acmd12_req_i && !a12_pend && !(busy && cur_is_a12);
  assign cmd_err = |iss_err_i;

  assign cmd_inhibit_o = busy | drv_pend | a12_pend;

  always_ff @(posedge clk_i) begin
    if (rst_i || sw_rst_cmd_i) begin
      state          <= IDLE;
      cur_is_a12     <= 1'b0;
      drv_pend       <= 1'b0;
      a12_pend       <= 1'b0;
      drv_index_q    <= '0;
      drv_arg_q      <= '0;
      drv_rsp_type_q <= '0;
      iss_valid_o    <= 1'b0;
      iss_index_o    <= '0;
      iss_arg_o      <= '0;
      iss_rsp_type_o <= '0;
      nerr_set_o     <= '0;
      aerr_set_o     <= '0;
      drv_done_o     <= 1'b0;
      acmd12_done_o  <= 1'b0;
    end else begin
      nerr_set_o    <= '0;
      aerr_set_o    <= '0;
      drv_done_o    <= 1'b0;
      acmd12_done_o <= 1'b0;

      if (drv_new) begin
        drv_index_q    <= drv_index_i;
        drv_arg_q      <= drv_arg_i;
        drv_rsp_type_q <= drv_rsp_type_i;
      end

      if (busy) begin
        if (drv_new) drv_pend <= 1'b1;
        if (a12_new) a12_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Auto CMD12 always wins; a driver request arriving alongside it waits.
          if (a12_pend || a12_new) begin
            state          <= OFFER;
            cur_is_a12     <= 1'b1;
            a12_pend       <= 1'b0;
            iss_valid_o    <= 1'b1;
            iss_index_o    <= Cmd12Ix;
            iss_arg_o      <= '0;
            iss_rsp_type_o <= 2'b11;
            if (drv_new) drv_pend <= 1'b1;
          end else if (drv_pend || drv_new) begin
            state          <= OFFER;
            cur_is_a12     <= 1'b0;
            drv_pend       <= 1'b0;
            iss_valid_o    <= 1'b1;
            iss_index_o    <= drv_new ? drv_index_i : drv_index_q;
            iss_arg_o      <= drv_new ? drv_arg_i : drv_arg_q;
            iss_rsp_type_o <= drv_new ? drv_rsp_type_i : drv_rsp_type_q;
          end
        end
        OFFER: begin
          if (iss_ready_i) begin
            state       <= WAIT;
            iss_valid_o <= 1'b0;
          end
        end
        WAIT: begin
          if (iss_done_i) begin
            state <= IDLE;
            if (cur_is_a12) begin
              aerr_set_o[4:1] <= iss_err_i[3:0];
              acmd12_done_o   <= !cmd_err;
              if (GateEn && cmd_err && (drv_pend || drv_new)) begin
                drv_pend      <= 1'b0;
                aerr_set_o[7] <= 1'b1;
              end
            end else begin
              nerr_set_o <= iss_err_i[3:0];
              drv_done_o <= !cmd_err;
              if (GateEn && cmd_err && (a12_pend || a12_new)) begin
                a12_pend      <= 1'b0;
                aerr_set_o[0] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Bench for sdhci_cmd_arbiter: a behavioural issuer plus a transaction-level model of ordering and error gating.
// Expectations follow SDHCI_ACMD12_ERR_GATE_EN the same way the design does.
`timescale 1ns/1ps

module tb_sdhci_cmd_arbiter;

`ifdef SDHCI_ACMD12_ERR_GATE_EN
  localparam bit GateEn = 1'b1;
`else
  localparam bit GateEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sw_rst_cmd_i = 1'b0;
  logic        drv_req_i = 1'b0;
  logic [5:0]  drv_index_i = '0;
  logic [31:0] drv_arg_i = '0;
  logic [1:0]  drv_rsp_type_i = '0;
  logic        acmd12_req_i = 1'b0;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic [5:0]  iss_index_o;
  logic [31:0] iss_arg_o;
  logic [1:0]  iss_rsp_type_o;
  logic        iss_done_i;
  logic [3:0]  iss_err_i;
  logic        cmd_inhibit_o;
  logic [3:0]  nerr_set_o;
  logic [7:0]  aerr_set_o;
  logic        drv_done_o;
  logic        acmd12_done_o;

  // Issuer inputs come from the behavioural issuer or from manual steps.
  bit         resp_en = 1'b1;
  logic       b_ready = 1'b0, b_done = 1'b0, m_ready = 1'b0, m_done = 1'b0;
  logic [3:0] b_err = '0, m_err = '0;
  assign iss_ready_i = resp_en ? b_ready : m_ready;
  assign iss_done_i  = resp_en ? b_done  : m_done;
  assign iss_err_i   = resp_en ? b_err   : m_err;

  sdhci_cmd_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .sw_rst_cmd_i(sw_rst_cmd_i),
    .drv_req_i(drv_req_i), .drv_index_i(drv_index_i), .drv_arg_i(drv_arg_i),
    .drv_rsp_type_i(drv_rsp_type_i), .acmd12_req_i(acmd12_req_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_index_o(iss_index_o),
    .iss_arg_o(iss_arg_o), .iss_rsp_type_o(iss_rsp_type_o), .iss_done_i(iss_done_i),
    .iss_err_i(iss_err_i), .cmd_inhibit_o(cmd_inhibit_o), .nerr_set_o(nerr_set_o),
    .aerr_set_o(aerr_set_o), .drv_done_o(drv_done_o), .acmd12_done_o(acmd12_done_o)
  );

  always #5 clk_i = ~clk_i;

  int          tests = 0;
  int          fails = 0;
  int          drv_done_cnt = 0, a12_done_cnt = 0;
  logic [3:0]  nerr_acc = '0;
  logic [7:0]  aerr_acc = '0;
  logic        after_done_inh = 1'b1;
  int          b_state = 0, rdy_cnt = 0, done_cnt = 0, rdy_dly = 0, done_dly = 1;
  logic [39:0] exp_offers[$];
  logic [39:0] obs_offers[$];
  logic [3:0]  err_q[$];

  // Behavioural issuer: accepts offers after rdy_dly cycles and answers done_dly cycles later.
  initial begin
    forever begin
      @(negedge clk_i);
      if (drv_done_o) drv_done_cnt++;
      if (acmd12_done_o) a12_done_cnt++;
      nerr_acc |= nerr_set_o;
      aerr_acc |= aerr_set_o;
      if (resp_en) begin
        case (b_state)
          0: begin
            if (!iss_valid_o) rdy_cnt = rdy_dly;
            else if (rdy_cnt == 0) begin
              b_ready = 1'b1;
              obs_offers.push_back({iss_index_o, iss_arg_o, iss_rsp_type_o});
              done_cnt = done_dly;
              b_state = 2;
            end else rdy_cnt--;
          end
          2: begin
            b_ready = 1'b0;
            if (done_cnt <= 1) begin
              b_done = 1'b1;
              b_err = 4'h0;
              if (err_q.size() > 0) b_err = err_q.pop_front();
              b_state = 3;
            end else done_cnt--;
          end
          default: begin
            b_done = 1'b0;
            b_err = 4'h0;
            after_done_inh = cmd_inhibit_o;
            b_state = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearObs();
    exp_offers.delete();
    obs_offers.delete();
    err_q.delete();
    drv_done_cnt = 0;
    a12_done_cnt = 0;
    nerr_acc = '0;
    aerr_acc = '0;
    after_done_inh = 1'b1;
  endtask

  task automatic driveDrv(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    drv_req_i = 1'b1;
    drv_index_i = idx;
    drv_arg_i = arg;
    drv_rsp_type_i = typ;
  endtask

  // mode: 0 driver only, 1 ACMD12 only, 2 same cycle, 3 driver then ACMD12, 4 ACMD12 then driver.
  task automatic applyStimulus(input int mode, input int gap, input logic [3:0] e1, input logic [3:0] e2,
                               input logic [1:0] dtype, input int rdy, input int dly);
    logic [5:0]  didx;
    logic [31:0] darg;
    logic [39:0] drv_cmd, a12_cmd;
    bit          a_first, two, gated, quiet;
    bit          own_a12[2];
    logic [3:0]  errv[2];
    int          n;
    logic [7:0]  exp_aerr;
    logic [3:0]  exp_nerr;
    int          exp_dd, exp_ad;

    clearObs();
    didx = 6'($urandom_range(0, 63));
    darg = $urandom;
    drv_cmd = {didx, darg, dtype};
    a12_cmd = {6'd12, 32'd0, 2'b11};
    two = (mode >= 2);
    a_first = (mode == 1) || (mode == 2) || (mode == 4);
    gated = GateEn && two && (e1 != 4'h0);

    own_a12[0] = a_first; errv[0] = e1; n = 1;
    own_a12[1] = !a_first; errv[1] = e2;
    if (two && !gated) n = 2;
    exp_aerr = '0; exp_nerr = '0; exp_dd = 0; exp_ad = 0;
    for (int i = 0; i < n; i++) begin
      exp_offers.push_back(own_a12[i] ? a12_cmd : drv_cmd);
      err_q.push_back(errv[i]);
      if (own_a12[i]) begin
        exp_aerr |= {3'b000, errv[i], 1'b0};
        if (errv[i] == 4'h0) exp_ad++;
      end else begin
        exp_nerr |= errv[i];
        if (errv[i] == 4'h0) exp_dd++;
      end
    end
    if (gated) exp_aerr |= a_first ? 8'h80 : 8'h01;
    rdy_dly = rdy;
    done_dly = dly;

    if (mode == 0 || mode == 2 || mode == 3) driveDrv(didx, darg, dtype);
    if (mode == 1 || mode == 2 || mode == 4) acmd12_req_i = 1'b1;
    @(negedge clk_i);
    drv_req_i = 1'b0;
    acmd12_req_i = 1'b0;
    drv_arg_i = $urandom;
    drv_index_i = 6'($urandom_range(0, 63));
    checkOutput("offer_latency", 64'(iss_valid_o), 64'd1);
    if (mode >= 3) begin
      repeat (gap - 1) @(negedge clk_i);
      if (mode == 3) acmd12_req_i = 1'b1;
      else driveDrv(didx, darg, dtype);
      @(negedge clk_i);
      drv_req_i = 1'b0;
      acmd12_req_i = 1'b0;
      drv_arg_i = $urandom;
    end

    quiet = 1'b0;
    for (int c = 0; c < 3000 && !quiet; c++) begin
      @(negedge clk_i);
      if (!cmd_inhibit_o && b_state == 0) quiet = 1'b1;
    end
    repeat (3) @(negedge clk_i);
    checkOutput("round_completes", 64'(quiet), 64'd1);
    checkOutput("offer_count", 64'(obs_offers.size()), 64'(exp_offers.size()));
    for (int i = 0; i < exp_offers.size() && i < obs_offers.size(); i++)
      checkOutput($sformatf("offer%0d_payload", i), 64'(obs_offers[i]), 64'(exp_offers[i]));
    checkOutput("drv_done_pulses", 64'(drv_done_cnt), 64'(exp_dd));
    checkOutput("acmd12_done_pulses", 64'(a12_done_cnt), 64'(exp_ad));
    checkOutput("nerr_set", 64'(nerr_acc), 64'(exp_nerr));
    checkOutput("aerr_set", 64'(aerr_acc), 64'(exp_aerr));
    checkOutput("inhibit_after_done", 64'(after_done_inh), 64'd0);
  endtask

  initial begin
    int         mode, gap, rdy, dly;
    logic [3:0] e1, e2;
    bit         valid_seen;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_valid", 64'(iss_valid_o), 64'd0);
    checkOutput("reset_inhibit", 64'(cmd_inhibit_o), 64'd0);
    checkOutput("reset_pulses", 64'({nerr_set_o, aerr_set_o, drv_done_o, acmd12_done_o}), 64'd0);

    $display("[TB] directed: single driver command");
    applyStimulus(0, 1, 4'h0, 4'h0, 2'b10, 0, 50);
    $display("[TB] directed: simultaneous requests, no errors");
    applyStimulus(2, 1, 4'h0, 4'h0, 2'b01, 1, 8);
    $display("[TB] directed: simultaneous requests, ACMD12 fails");
    applyStimulus(2, 1, 4'b1010, 4'h0, 2'b10, 0, 10);
    repeat (320) @(negedge clk_i);
    checkOutput("no_late_offer", 64'(obs_offers.size()), 64'(exp_offers.size()));
    $display("[TB] directed: driver first and fails");
    applyStimulus(3, 1, 4'b1010, 4'h0, 2'b10, 0, 10);

    $display("[TB] directed: CMD line soft reset during WAIT");
    clearObs();
    resp_en = 1'b0;
    acmd12_req_i = 1'b1;
    @(negedge clk_i);
    acmd12_req_i = 1'b0;
    m_ready = 1'b1;
    @(negedge clk_i);
    m_ready = 1'b0;
    driveDrv(6'd17, 32'h1234_5678, 2'b10);
    @(negedge clk_i);
    drv_req_i = 1'b0;
    checkOutput("swrst_pre_inhibit", 64'(cmd_inhibit_o), 64'd1);
    sw_rst_cmd_i = 1'b1;
    @(negedge clk_i);
    sw_rst_cmd_i = 1'b0;
    checkOutput("swrst_inhibit", 64'(cmd_inhibit_o), 64'd0);
    checkOutput("swrst_valid", 64'(iss_valid_o), 64'd0);
    m_done = 1'b1;
    m_err = 4'b1010;
    @(negedge clk_i);
    m_done = 1'b0;
    m_err = 4'h0;
    valid_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      valid_seen |= iss_valid_o;
    end
    checkOutput("swrst_no_offer", 64'(valid_seen), 64'd0);
    checkOutput("swrst_no_pulses", 64'({nerr_acc, aerr_acc}), 64'd0);
    checkOutput("swrst_no_done", 64'(drv_done_cnt + a12_done_cnt), 64'd0);
    resp_en = 1'b1;

    $display("[TB] random rounds");
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(0, 4);
      gap  = $urandom_range(1, 3);
      e1   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      e2   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rdy  = $urandom_range(0, 3);
      dly  = $urandom_range(gap + 4, 20);
      applyStimulus(mode, gap, e1, e2, 2'($urandom_range(0, 3)), rdy, dly);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
